// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the N-channel buzzer arbiter.
// The helpers work on a fixed 16-bit vector so that any build with N <= 16 can use them.
package buzzer_pkg;

   localparam int MAX_N     = 16;
   localparam int IDX_MAX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      DECIDED = 2'd2
   } state_t;

   // Searches downward so the last hit written is the lowest set index.
   function automatic logic [IDX_MAX_W-1:0] lowest_index(input logic [MAX_N-1:0] vec);
      logic [IDX_MAX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_MAX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic multi_hot(input logic [MAX_N-1:0] vec);
      return ($countones(vec) >= 2);
   endfunction

endpackage

// File: rtl/buzzer_arbiter_edge_det_n.sv
// N-wide rising-edge detector: registers pb every cycle and flags 0->1 transitions.
module edge_det_n #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] pb,
   output logic [N-1:0] press
);

   logic [N-1:0] pb_q;

   // NOTE: sequential state is written with <= so every register samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) pb_q <= '0;
      else     pb_q <= pb;
   end

   assign press = pb & ~pb_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// First-press arbiter: arm/disarm rounds, false-start lockout, lowest-index tie-break, timeout.
// The FSM, timeout counter and every result register live in one clocked block.
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int N              = 4,
   parameter int IDXW           = (N > 1) ? $clog2(N) : 1,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNTW           = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    pb,
   input  logic            arm,
   input  logic            clear,
   output logic            push,
   output logic            tie,
   output logic [IDXW-1:0] winner,
   output logic [N-1:0]    win_onehot,
   output logic [N-1:0]    false_start,
   output logic            timeout,
   output logic            armed
);

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(TIMEOUT_CYCLES - 1);

   state_t                 state;
   logic [CNTW-1:0]        counter;
   logic [N-1:0]           press;
   logic [N-1:0]           v;
   logic [IDX_MAX_W-1:0]   low_full;
   logic                   many;

   edge_det_n #(.N(N)) u_edge (
      .clk   (clk),
      .rst   (rst),
      .pb    (pb),
      .press (press)
   );

   // Channels that false-started this round are locked out.
   assign v        = press & ~false_start;
   assign low_full = lowest_index(MAX_N'(v));
   assign many     = multi_hot(MAX_N'(v));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         push        <= 1'b0;
         tie         <= 1'b0;
         winner      <= '0;
         win_onehot  <= '0;
         false_start <= '0;
         timeout     <= 1'b0;
         armed       <= 1'b0;
         counter     <= '0;
      end else if (clear) begin
         state       <= IDLE;
         push        <= 1'b0;
         tie         <= 1'b0;
         winner      <= '0;
         win_onehot  <= '0;
         false_start <= '0;
         timeout     <= 1'b0;
         armed       <= 1'b0;
         counter     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               false_start <= false_start | press;
               if (arm) begin
                  state   <= ARMED;
                  armed   <= 1'b1;
                  counter <= '0;
               end
            end
            ARMED: begin
               if (v != '0) begin
                  state      <= DECIDED;
                  armed      <= 1'b0;
                  push       <= 1'b1;
                  win_onehot <= v;
                  winner     <= low_full[IDXW-1:0];
                  tie        <= many;
               end else if (TIMEOUT_CYCLES != 0 && counter == LAST_CNT) begin
                  state   <= DECIDED;
                  armed   <= 1'b0;
                  timeout <= 1'b1;
               end else if (counter != '1) begin
                  counter <= counter + 1'b1;
               end
            end
            DECIDED: begin
               // Results hold until clear.
            end
            default: begin
               state <= IDLE;
               armed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed self-checking bench for buzzer_arbiter (N=4, timeout 16) plus a timeout-disabled build.
module tb_buzzer_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pb;
   logic       arm;
   logic       clear;

   logic       push, tie, timeout, armed;
   logic [1:0] winner;
   logic [3:0] win_onehot, false_start;

   logic       push0, tie0, timeout0, armed0;
   logic [1:0] winner0;
   logic [3:0] win_onehot0, false_start0;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   buzzer_arbiter #(.N(4), .TIMEOUT_CYCLES(16), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .pb(pb), .arm(arm), .clear(clear),
      .push(push), .tie(tie), .winner(winner), .win_onehot(win_onehot),
      .false_start(false_start), .timeout(timeout), .armed(armed)
   );

   buzzer_arbiter #(.N(4), .TIMEOUT_CYCLES(0), .CNTW(16)) dut_nto (
      .clk(clk), .rst(rst), .pb(pb), .arm(arm), .clear(clear),
      .push(push0), .tie(tie0), .winner(winner0), .win_onehot(win_onehot0),
      .false_start(false_start0), .timeout(timeout0), .armed(armed0)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic p, input logic t, input logic [1:0] w,
                            input logic [3:0] oh, input logic [3:0] fs, input logic to, input logic a);
      check({tag, ".push"},        32'(push),        32'(p));
      check({tag, ".tie"},         32'(tie),         32'(t));
      check({tag, ".winner"},      32'(winner),      32'(w));
      check({tag, ".win_onehot"},  32'(win_onehot),  32'(oh));
      check({tag, ".false_start"}, 32'(false_start), 32'(fs));
      check({tag, ".timeout"},     32'(timeout),     32'(to));
      check({tag, ".armed"},       32'(armed),       32'(a));
   endtask

   initial begin
      rst = 1'b1; pb = '0; arm = 1'b0; clear = 1'b0;
      tick(2);
      rst = 1'b0;
      check_all("reset", 0, 0, 2'd0, 4'h0, 4'h0, 0, 0);

      // Single winner on channel 2, later presses ignored.
      clear = 1'b1; tick(); clear = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      check("arm.armed", 32'(armed), 32'd1);
      pb = 4'b0100; tick();
      check_all("win2", 1, 0, 2'd2, 4'b0100, 4'h0, 0, 0);
      pb = 4'b0000; tick();
      pb = 4'b0001; tick();
      check_all("win2_hold", 1, 0, 2'd2, 4'b0100, 4'h0, 0, 0);
      pb = 4'b0000; tick();

      // Tie between channels 1 and 3.
      clear = 1'b1; tick(); clear = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      pb = 4'b1010; tick();
      check_all("tie", 1, 1, 2'd1, 4'b1010, 4'h0, 0, 0);
      pb = 4'b0000; clear = 1'b1; tick(); clear = 1'b0;
      check_all("tie_clear", 0, 0, 2'd0, 4'h0, 4'h0, 0, 0);

      // False start on channel 3 locks it out for the round.
      pb = 4'b1000; tick();
      check("fs3", 32'(false_start), 32'b1000);
      pb = 4'b0000; tick();
      arm = 1'b1; tick(); arm = 1'b0;
      pb = 4'b1000; tick();
      check("fs3_locked.push", 32'(push), 32'd0);
      check("fs3_locked.armed", 32'(armed), 32'd1);
      pb = 4'b0000; tick();
      pb = 4'b0001; tick();
      check_all("fs3_win0", 1, 0, 2'd0, 4'b0001, 4'b1000, 0, 0);
      pb = 4'b0000; clear = 1'b1; tick(); clear = 1'b0;
      check("fs3_cleared", 32'(false_start), 32'h0);

      // Button held across arm never wins; round times out after 16 armed cycles.
      pb = 4'b0010; tick();
      arm = 1'b1; tick(); arm = 1'b0;
      tick(15);
      check("to_pre.timeout", 32'(timeout), 32'd0);
      check("to_pre.armed", 32'(armed), 32'd1);
      tick();
      check_all("to", 0, 0, 2'd0, 4'h0, 4'b0010, 1, 0);
      pb = 4'b0000; tick();
      pb = 4'b0010; tick();
      check_all("to_hold", 0, 0, 2'd0, 4'h0, 4'b0010, 1, 0);
      pb = 4'b0000; clear = 1'b1; tick(); clear = 1'b0;

      // clear beats a press, and clear beats arm.
      arm = 1'b1; tick(); arm = 1'b0;
      pb = 4'b0100; clear = 1'b1; tick(); clear = 1'b0;
      check_all("clr_press", 0, 0, 2'd0, 4'h0, 4'h0, 0, 0);
      pb = 4'b0000; tick();
      arm = 1'b1; clear = 1'b1; tick(); arm = 1'b0; clear = 1'b0;
      check("clr_arm.armed", 32'(armed), 32'd0);
      tick();
      check("clr_arm.armed_later", 32'(armed), 32'd0);

      // rst mid-round with a press on the same edge.
      arm = 1'b1; tick(); arm = 1'b0;
      rst = 1'b1; pb = 4'b0001; tick(); rst = 1'b0;
      pb = 4'b0000;
      check_all("rst_mid", 0, 0, 2'd0, 4'h0, 4'h0, 0, 0);
      tick();
      check_all("rst_after", 0, 0, 2'd0, 4'h0, 4'h0, 0, 0);

      // Long armed period: timeout-disabled build never expires.
      arm = 1'b1; tick(); arm = 1'b0;
      tick(5000);
      check("long.timeout16", 32'(timeout), 32'd1);
      check("long.nto.timeout", 32'(timeout0), 32'd0);
      check("long.nto.armed", 32'(armed0), 32'd1);
      check("long.nto.push", 32'(push0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- N-channel first-press arbiter for the push-button reaction game. Generalises the two-button left/right latch to N players.
- Adds an arm/disarm round protocol, rising-edge press detection, false-start lockout, a lowest-index tie-break and a round timeout.
- Sits between the upstream button synchronisers/debouncers and the display/score logic.
- All inputs are already synchronous to clk.

Parameters:
- N, 4, number of player channels (2..16).
- IDXW, $clog2(N) (min 1), width of the winner index.
- TIMEOUT_CYCLES, 1000, cycles from arm to automatic no-winner decision; 0 disables the timeout.
- CNTW, 16, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNTW.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- pb, input, N, level of each player button (1 = pressed).
- arm, input, 1, one-cycle pulse that opens a round.
- clear, input, 1, ends the round and clears all results.
- push, output, 1, a winning press has been latched (sticky).
- tie, output, 1, two or more first presses landed in the same cycle (sticky).
- winner, output, IDXW, index of the winning channel; valid while push=1.
- win_onehot, output, N, every channel that pressed in the deciding cycle.
- false_start, output, N, sticky per-channel flag for a press made while not armed.
- timeout, output, 1, round expired with no valid press.
- armed, output, 1, high while in the ARMED state.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - On rst: state=IDLE; push=0, tie=0, winner=0, win_onehot=0, false_start=0, timeout=0, armed=0, counter=0, pb_q=0.
  - rst overrides every other input.
- Press detection: press[i] = pb[i] & ~pb_q[i], where pb_q is pb registered every cycle (including during IDLE).
  - A button held across arm never counts as a press.
- State IDLE:
  - Any press[i] sets false_start[i].
  - arm=1 -> ARMED and counter=0. A press sampled on the same edge as arm is still treated as a false start.
- State ARMED (armed=1):
  - Valid presses are v = press & ~false_start. Locked-out channels are ignored.
  - If v != 0, then on that edge:
    - Go to DECIDED.
    - push=1, win_onehot=v.
    - winner = lowest set index of v.
    - tie = 1 if popcount(v) >= 2, else 0.
  - Latency: push is high in the cycle after the edge that first samples the press.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: go to DECIDED, timeout=1, push=0.
  - Otherwise the counter increments; it saturates and never wraps.
  - arm while ARMED is ignored; the counter is not restarted.
- State DECIDED:
  - All outputs hold.
  - Further presses and arm are ignored, and false_start does not change.
- clear, in any state:
  - Next state IDLE.
  - Clears push, tie, winner, win_onehot, false_start, timeout and the counter.
  - clear beats arm and press on the same edge; such a press is discarded, not flagged as a false start.
- Output invariants:
  - push and timeout are never both 1.
  - tie implies push.
  - All outputs are registered.

Decomposition:
- Shared package buzzer_pkg holds:
  - the state enum {IDLE, ARMED, DECIDED};
  - the function lowest_index(vec) returning IDXW bits;
  - the function multi_hot(vec) returning 1 when popcount >= 2.
- One natural sub-module, edge_det_n: N-wide pb_q register plus rising-edge output, cleared by rst.
- The FSM, counter and result registers stay in buzzer_arbiter.

Test Plan:
- N=4, TIMEOUT=16. rst 2 cycles, clear, arm, then pb=4'b0100 at cycle 3 -> push=1 the next cycle, winner=2, win_onehot=0100, tie=0. A later pb=0001 leaves all outputs unchanged.
- Armed, pb=4'b1010 rising in the same cycle -> push=1, tie=1, winner=1, win_onehot=1010. Then clear -> all outputs 0, armed=0.
- IDLE, pb[3] pulses -> false_start=1000. Then arm and pb[3] pulses again -> ignored, push=0. Then pb[0] rises -> winner=0. false_start stays 1000 until clear.
- arm with pb[1] held since before arm and no other press -> no win. After 16 cycles timeout=1, push=0, armed=0. Releasing and re-pressing pb[1] afterwards is ignored.
- clear and a pb[2] rise on the same edge while ARMED -> state IDLE, push=0, false_start=0. arm and clear on the same edge -> stays IDLE.
- rst asserted mid-ARMED with a press on the same edge -> all outputs 0, state IDLE, no false_start. TIMEOUT_CYCLES=0 build: armed for 5000 cycles -> timeout stays 0.
